// File: rtl/check_pc.sv
// Instruction-memory address range checker for the Y86 SEQ fetch stage.
// Flags any byte address at or beyond MEM_BYTES. It also keeps a small error log:
// a sticky flag, a saturating fault count and the first faulting address.
module check_pc #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              clr_err,
  output logic              addrerror,
  output logic              addrerror_q,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_BYTES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  typedef enum logic [0:0] {StClean, StFaulted} state_e;

  state_e            state_q, state_d;
  logic              ae_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Pure unsigned compare; fetch samples it on the same edge as the memory read.
  assign addrerror = (pc > LastAddr);

  // State and log registers; synchronous active-low reset wipes all history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StClean;
      ae_q    <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ae_q    <= addrerror;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  // Sticky-flag transitions: clear has priority over a same-cycle fault.
  always_comb begin
    state_d = state_q;
    if (clr_err) begin
      state_d = StClean;
    end else if (addrerror) begin
      state_d = StFaulted;
    end
  end

  // Log datapath: saturating count, address captured only on the first fault.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    if (clr_err) begin
      count_d = '0;
      addr_d  = '0;
    end else if (addrerror) begin
      if (count_q != CntMax) begin
        count_d = count_q + CNT_W'(1);
      end
      if (state_q == StClean) begin
        addr_d = pc;
      end
    end
  end

  // Registered outputs decoded from state.
  always_comb begin
    err_sticky = 1'b0;
    unique case (state_q)
      StClean:   err_sticky = 1'b0;
      StFaulted: err_sticky = 1'b1;
      default:   err_sticky = 1'b0;
    endcase
    addrerror_q = ae_q;
    err_count   = count_q;
    err_addr    = addr_q;
  end

endmodule

// File: tb/tb_check_pc.sv
// Self-checking bench for check_pc (MEM_BYTES=1024, ADDR_W=64, CNT_W=4).
// Expected register values are pushed to a queue as each cycle is driven and
// popped after the following rising edge.
module tb_check_pc;

  localparam int unsigned CntW = 4;

  typedef struct packed {
    logic            aq;
    logic            st;
    logic [CntW-1:0] cnt;
    logic [63:0]     addr;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [63:0]     pc = '0;
  logic            clr_err = 1'b0;
  logic            addrerror;
  logic            addrerror_q;
  logic            err_sticky;
  logic [CntW-1:0] err_count;
  logic [63:0]     err_addr;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];
  logic exp_ae;

  // Reference model of the error log.
  logic            m_st = 1'b0;
  logic [CntW-1:0] m_cnt = '0;
  logic [63:0]     m_addr = '0;
  logic            m_aq = 1'b0;

  check_pc #(
    .MEM_BYTES(1024),
    .ADDR_W   (64),
    .CNT_W    (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .clr_err    (clr_err),
    .addrerror  (addrerror),
    .addrerror_q(addrerror_q),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.aq   = addrerror_q;
    o.st   = err_sticky;
    o.cnt  = err_count;
    o.addr = err_addr;
    return o;
  endfunction

  // Apply one cycle of stimulus and push the expected post-edge state.
  task automatic drive(input logic [63:0] p, input logic c, input logic r);
    obs_t e;
    pc      = p;
    clr_err = c;
    rst_n   = r;
    exp_ae  = (p >= 64'd1024);
    if (!r) begin
      m_aq = 1'b0; m_st = 1'b0; m_cnt = '0; m_addr = '0;
    end else begin
      m_aq = exp_ae;
      if (c) begin
        m_st = 1'b0; m_cnt = '0; m_addr = '0;
      end else if (exp_ae) begin
        if (!m_st) m_addr = p;
        m_st = 1'b1;
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
    end
    e.aq = m_aq; e.st = m_st; e.cnt = m_cnt; e.addr = m_addr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      drive((i == 1) ? 64'd1024 : 64'd0, (i == 2), 1'b0);
      #1;
      n_cmp++;
      if (addrerror !== exp_ae) begin
        n_bad++;
        $display("FAIL reset_comb i=%0d got=%0b exp=%0b", i, addrerror, exp_ae);
      end
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_reg i=%0d got aq=%0b st=%0b cnt=%0d addr=%0h exp aq=%0b st=%0b cnt=%0d addr=%0h",
                 i, got.aq, got.st, got.cnt, got.addr, exp.aq, exp.st, exp.cnt, exp.addr);
      end
    end
  endtask

  task automatic test_boundary();
    logic [63:0] pcs [4] = '{64'd0, 64'd1023, 64'd1024, 64'hFFFF_FFFF_FFFF_FFFF};
    obs_t got, exp;
    drive(64'd0, 1'b0, 1'b0); @(posedge clk); #1; void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(pcs[i], 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (addrerror !== exp_ae) begin
        n_bad++;
        $display("FAIL boundary_comb pc=%0h got=%0b exp=%0b", pcs[i], addrerror, exp_ae);
      end
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL boundary_reg pc=%0h got aq=%0b st=%0b cnt=%0d addr=%0h exp aq=%0b st=%0b cnt=%0d addr=%0h",
                 pcs[i], got.aq, got.st, got.cnt, got.addr, exp.aq, exp.st, exp.cnt, exp.addr);
      end
    end
  endtask

  task automatic test_first_fault();
    logic [63:0] pcs [4] = '{64'd500, 64'd2000, 64'd1500, 64'd10};
    obs_t got, exp;
    drive(64'd0, 1'b0, 1'b0); @(posedge clk); #1; void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(pcs[i], 1'b0, 1'b1);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL first_fault pc=%0d got st=%0b cnt=%0d addr=%0d exp st=%0b cnt=%0d addr=%0d",
                 pcs[i], got.st, got.cnt, got.addr, exp.st, exp.cnt, exp.addr);
      end
    end
    n_cmp++;
    if (err_addr !== 64'd2000 || err_count !== 4'd2 || err_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL first_fault_final got addr=%0d cnt=%0d st=%0b exp addr=2000 cnt=2 st=1",
               err_addr, err_count, err_sticky);
    end
  endtask

  task automatic test_clear_priority();
    obs_t got, exp;
    drive(64'd0, 1'b0, 1'b0); @(posedge clk); #1; void'(exp_q.pop_front());
    // Five faults, a clear with a fault present, then a new first fault.
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       drive(64'd1024 + 64'(i), 1'b0, 1'b1);
      else if (i == 5) drive(64'd4096, 1'b1, 1'b1);
      else             drive(64'd3000, 1'b0, 1'b1);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL clear_priority i=%0d got aq=%0b st=%0b cnt=%0d addr=%0d exp aq=%0b st=%0b cnt=%0d addr=%0d",
                 i, got.aq, got.st, got.cnt, got.addr, exp.aq, exp.st, exp.cnt, exp.addr);
      end
    end
  endtask

  task automatic test_saturation();
    obs_t got, exp;
    drive(64'd0, 1'b0, 1'b0); @(posedge clk); #1; void'(exp_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(64'd1024, 1'b0, 1'b1);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL saturation i=%0d got st=%0b cnt=%0d exp st=%0b cnt=%0d",
                 i, got.st, got.cnt, exp.st, exp.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_fault();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      drive(64'd1024, 1'b0, (i != 3));
      #1;
      n_cmp++;
      if (addrerror !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_mid_comb i=%0d got=%0b exp=1", i, addrerror);
      end
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_mid_reg i=%0d got aq=%0b st=%0b cnt=%0d addr=%0d exp aq=%0b st=%0b cnt=%0d addr=%0d",
                 i, got.aq, got.st, got.cnt, got.addr, exp.aq, exp.st, exp.cnt, exp.addr);
      end
    end
  endtask

  task automatic test_fetch();
    logic [63:0] offs [4] = '{64'd0, 64'd1, 64'd8, 64'd9};
    for (int i = 0; i < 4; i++) begin
      drive(64'd1015 + offs[i], 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (addrerror !== exp_ae) begin
        n_bad++;
        $display("FAIL fetch off=%0d got=%0b exp=%0b", offs[i], addrerror, exp_ae);
      end
      @(posedge clk); #1;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    logic [63:0] p;
    drive(64'd0, 1'b0, 1'b0); @(posedge clk); #1; void'(exp_q.pop_front());
    for (int i = 0; i < 60; i++) begin
      p = 64'(1020 + $urandom_range(0, 8));
      if ($urandom_range(0, 9) == 0) p = {$urandom(), $urandom()};
      drive(p, ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) != 0));
      #1;
      n_cmp++;
      if (addrerror !== exp_ae) begin
        n_bad++;
        $display("FAIL b2b_comb i=%0d pc=%0h got=%0b exp=%0b", i, p, addrerror, exp_ae);
      end
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL b2b_reg i=%0d got aq=%0b st=%0b cnt=%0d addr=%0h exp aq=%0b st=%0b cnt=%0d addr=%0h",
                 i, got.aq, got.st, got.cnt, got.addr, exp.aq, exp.st, exp.cnt, exp.addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_first_fault();
    test_clear_priority();
    test_saturation();
    test_reset_mid_fault();
    test_fetch();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d left exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
